// File: rtl/agc_parity_sreg_unit_pkg.sv
// Shared definitions for the S-register / G-parity unit: default widths,
// erasable address-map boundaries and the parity-check sequencer states.
package agc_parity_pkg;

  localparam int unsigned DEF_DATA_W  = 15;
  localparam int unsigned DEF_ADDR_W  = 12;
  localparam int unsigned DEF_EBANK_W = 3;
  localparam int unsigned DEF_CNT_W   = 8;

  // Erasable map: 0o0000-0o1377 fixed-erasable banks 0-2, 0o1400-0o1777 switched
  localparam logic [31:0] EB_SWITCHED_BASE = 32'o1400;
  localparam logic [31:0] EB_LIMIT         = 32'o2000;
  localparam logic [31:0] LOWREG_LIMIT     = 32'd8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOADED = 2'd1,
    ST_CHECK  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/agc_parity_sreg_unit_if.sv
// Bus bundle between the write-bus/memory logic and the S/G parity unit.
// err_cnt exists only when AGC_PARITY_ERRCNT_EN is defined.
interface agc_parity_sreg_unit_if
  import agc_parity_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned EBANK_W = DEF_EBANK_W,
  parameter int unsigned CNT_W   = DEF_CNT_W
);

  logic                 gojam;
  logic [DATA_W-1:0]    wl;
  logic                 ws;
  logic                 wg;
  logic                 mem_rd;
  logic [DATA_W-1:0]    mem_data;
  logic                 mem_par;
  logic [EBANK_W-1:0]   ebank;
  logic                 chk_en;
  logic                 alarm_clr;

  logic [ADDR_W-1:0]    s;
  logic                 s_lowreg;
  logic [EBANK_W+7:0]   ead;
  logic [DATA_W-1:0]    g;
  logic                 g_par;
  logic                 g_nzero;
  logic                 par_alarm;
`ifdef AGC_PARITY_ERRCNT_EN
  logic [CNT_W-1:0]     err_cnt;
`endif

  modport master (
    output gojam, wl, ws, wg, mem_rd, mem_data, mem_par, ebank, chk_en, alarm_clr,
`ifdef AGC_PARITY_ERRCNT_EN
    input  err_cnt,
`endif
    input  s, s_lowreg, ead, g, g_par, g_nzero, par_alarm
  );

  modport slave (
    input  gojam, wl, ws, wg, mem_rd, mem_data, mem_par, ebank, chk_en, alarm_clr,
`ifdef AGC_PARITY_ERRCNT_EN
    output err_cnt,
`endif
    output s, s_lowreg, ead, g, g_par, g_nzero, par_alarm
  );

endinterface

// File: rtl/agc_parity_sreg_unit_ead.sv
// Combinational S/ebank -> effective erasable address and central-register flag.
// Shared with the fixed-bank successor unit.
module agc_ead_decode
  import agc_parity_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned EBANK_W = DEF_EBANK_W
) (
  input  logic [ADDR_W-1:0]  i_s,
  input  logic [EBANK_W-1:0] i_ebank,
  output logic               o_lowreg,
  output logic [EBANK_W+7:0] o_ead
);

  logic [31:0] w_s_ext;

  // Widening first keeps the boundary compares valid even when ADDR_W is 10
  assign w_s_ext  = 32'(i_s);
  assign o_lowreg = (w_s_ext < LOWREG_LIMIT);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    o_ead = '0;
    if (w_s_ext < EB_LIMIT) begin
      if (w_s_ext >= EB_SWITCHED_BASE) begin
        o_ead = {i_ebank, i_s[7:0]};
      end else begin
        o_ead = {EBANK_W'(i_s[9:8]), i_s[7:0]};
      end
    end
  end

endmodule

// File: rtl/agc_parity_sreg_unit.sv
// S address register, G register with odd parity and the 3-state parity-check
// sequencer driving a sticky alarm. Optional counter: AGC_PARITY_ERRCNT_EN.
module agc_parity_sreg_unit
  import agc_parity_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned EBANK_W = DEF_EBANK_W,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input logic                   CLOCK,
  input logic                   rst,
  agc_parity_sreg_unit_if.slave bus
);

  logic [ADDR_W-1:0]  r_s;
  logic [DATA_W-1:0]  r_g;
  logic               r_g_par;
  logic               r_g_nzero;
  seq_state_t         r_state;
  logic               r_mismatch;
  logic               r_pending;
  logic               r_fault;
  logic               r_par_alarm;

  seq_state_t         w_state_nxt;
  logic               w_capture;
  logic               w_pending_nxt;
  logic               w_lowreg;
  logic [EBANK_W+7:0] w_ead;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLOCK) begin
    if (rst || bus.gojam) begin
      r_s <= '0;
    end else if (bus.ws) begin
      r_s <= bus.wl[ADDR_W-1:0];
    end
  end

  always_ff @(posedge CLOCK) begin
    if (rst || bus.gojam) begin
      r_g       <= '0;
      r_g_par   <= 1'b0;
      r_g_nzero <= 1'b0;
    end else if (bus.mem_rd) begin
      r_g       <= bus.mem_data;
      r_g_par   <= bus.mem_par;
      r_g_nzero <= |bus.mem_data;
    end else if (bus.wg) begin
      r_g       <= bus.wl;
      r_g_par   <= ~^bus.wl;
      r_g_nzero <= |bus.wl;
    end
  end

  // A chk_en+mem_rd pair leaves an unchecked word in G, so CHECK returns to LOADED
  always_comb begin
    w_state_nxt   = r_state;
    w_capture     = 1'b0;
    w_pending_nxt = 1'b0;
    if (bus.gojam) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.mem_rd) w_state_nxt = ST_LOADED;
        end
        ST_LOADED: begin
          if (bus.chk_en) begin
            w_state_nxt   = ST_CHECK;
            w_capture     = 1'b1;
            w_pending_nxt = bus.mem_rd;
          end else if (bus.mem_rd) begin
            w_state_nxt = ST_LOADED;
          end else if (bus.wg) begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_CHECK: begin
          if (bus.mem_rd || (r_pending && !bus.wg)) begin
            w_state_nxt = ST_LOADED;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pending  <= 1'b0;
      r_mismatch <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      if (w_capture) begin
        r_mismatch <= ~^{r_g, r_g_par};
      end
      // gojam during CHECK drops the pending compare
      r_fault <= (r_state == ST_CHECK) && r_mismatch && !bus.gojam;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      r_par_alarm <= 1'b0;
    end else if (r_fault) begin
      r_par_alarm <= 1'b1;
    end else if (bus.alarm_clr) begin
      r_par_alarm <= 1'b0;
    end
  end

`ifdef AGC_PARITY_ERRCNT_EN
  logic [CNT_W-1:0] r_err_cnt;

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (r_fault) begin
      if (bus.alarm_clr) begin
        r_err_cnt <= CNT_W'(1);
      end else if (r_err_cnt != '1) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end else if (bus.alarm_clr) begin
      r_err_cnt <= '0;
    end
  end

  assign bus.err_cnt = r_err_cnt;
`endif

  agc_ead_decode #(
    .ADDR_W  (ADDR_W),
    .EBANK_W (EBANK_W)
  ) u_ead_decode (
    .i_s      (r_s),
    .i_ebank  (bus.ebank),
    .o_lowreg (w_lowreg),
    .o_ead    (w_ead)
  );

  assign bus.s         = r_s;
  assign bus.s_lowreg  = w_lowreg;
  assign bus.ead       = w_ead;
  assign bus.g         = r_g;
  assign bus.g_par     = r_g_par;
  assign bus.g_nzero   = r_g_nzero;
  assign bus.par_alarm = r_par_alarm;

endmodule
